// File: rtl/rf_iq_demod_pkg.sv
// Shared definitions for the RF I/Q demodulator.
//   out_state_e : output-register FSM states (EMPTY / FULL)
//   REF_POS/NEG : carrier reference levels that select +sample / -sample
//   acc_width() : accumulator/result width for a given sample width and window
package rf_iq_demod_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Mixing sign convention: reference high passes the sample, low negates it.
  localparam logic REF_POS = 1'b1;
  localparam logic REF_NEG = 1'b0;

  // One guard bit on top of sample+window growth keeps -(-2^(SW-1)) * 2^WL exact.
  function automatic int unsigned acc_width(input int unsigned sample_w,
                                            input int unsigned win_log2);
    return sample_w + win_log2 + 1;
  endfunction

endpackage

// File: rtl/rf_iq_demod_iq_mix_acc.sv
// Single-channel mixer and window accumulator.
//   clk, reset  : system clock, asynchronous active-high reset
//   sample_i    : stage-1 sample, already sign-extended by one bit
//   mix_ref_i   : carrier reference bit for this channel
//   vld_i       : stage-1 valid; accumulate on this cycle
//   last_i      : this valid sample closes the window
//   clr_i       : window restart, discards the partial sum
//   sum_o       : acc + current term (the window result when last_i is set)
module iq_mix_acc
  import rf_iq_demod_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned ACC_W    = 17
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [SAMPLE_W:0] sample_i,
  input  logic                    mix_ref_i,
  input  logic                    vld_i,
  input  logic                    last_i,
  input  logic                    clr_i,
  output logic signed [ACC_W-1:0] sum_o
);

  logic signed [SAMPLE_W:0]  term;
  logic signed [ACC_W-1:0]   term_ext;
  logic signed [ACC_W-1:0]   acc_q, acc_d;

  // Negation at SAMPLE_W+1 bits: the extra bit holds +2^(SAMPLE_W-1) exactly.
  always_comb begin
    term = (mix_ref_i == REF_POS) ? sample_i : -sample_i;
  end

  assign term_ext = {{(ACC_W-SAMPLE_W-1){term[SAMPLE_W]}}, term};
  assign sum_o    = acc_q + term_ext;

  // The closing sample is folded into sum_o and the accumulator restarts at 0
  // on the same edge, so the next window's first sample is never lost.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (vld_i) begin
      acc_d = last_i ? '0 : sum_o;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/rf_iq_demod.sv
// RF I/Q demodulator: mixes a signed RF sample stream with square-wave I and Q
// carrier references and integrates over windows of 2^WIN_LOG2 accepted samples.
//   clk, reset          : system clock, asynchronous active-high reset
//   rf_in, rf_i, rf_q   : RF sample and carrier references, taken when en=1
//   en                  : sample-accept enable
//   sync_clr            : window restart (output register and overrun untouched)
//   i_sum, q_sum        : held window result
//   out_valid/out_ready : result handshake
//   overrun/overrun_clr : sticky dropped-result flag and its clear
module rf_iq_demod
  import rf_iq_demod_pkg::*;
#(
  parameter  int unsigned SAMPLE_W = 8,
  parameter  int unsigned WIN_LOG2 = 8,
  localparam int unsigned ACC_W    = acc_width(SAMPLE_W, WIN_LOG2)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] rf_in,
  input  logic                       rf_i,
  input  logic                       rf_q,
  input  logic                       en,
  input  logic                       sync_clr,
  output logic signed [ACC_W-1:0]    i_sum,
  output logic signed [ACC_W-1:0]    q_sum,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overrun,
  input  logic                       overrun_clr
);

  logic signed [SAMPLE_W:0] s1_smp_q, s1_smp_d;
  logic                     s1_i_q, s1_i_d;
  logic                     s1_q_q, s1_q_d;
  logic                     s1_vld_q, s1_vld_d;
  logic [WIN_LOG2-1:0]      cnt_q, cnt_d;
  logic                     win_last;
  logic                     win_end;
  logic signed [ACC_W-1:0]  mix_i_sum, mix_q_sum;

  out_state_e               state_q, state_d;
  logic signed [ACC_W-1:0]  i_sum_q, i_sum_d;
  logic signed [ACC_W-1:0]  q_sum_q, q_sum_d;
  logic                     ovr_q, ovr_d;
  logic                     drop;

  // Stage 1: capture on en; a capture coinciding with sync_clr is discarded.
  always_comb begin
    s1_smp_d = s1_smp_q;
    s1_i_d   = s1_i_q;
    s1_q_d   = s1_q_q;
    s1_vld_d = en & ~sync_clr;
    if (en) begin
      s1_smp_d = {rf_in[SAMPLE_W-1], rf_in};
      s1_i_d   = rf_i;
      s1_q_d   = rf_q;
    end
  end

  // Window counter wraps naturally at 2^WIN_LOG2.
  always_comb begin
    cnt_d = cnt_q;
    if (sync_clr) begin
      cnt_d = '0;
    end else if (s1_vld_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign win_last = (cnt_q == '1);
  assign win_end  = s1_vld_q & win_last & ~sync_clr;

  iq_mix_acc #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_mix_i (
    .clk       (clk),
    .reset     (reset),
    .sample_i  (s1_smp_q),
    .mix_ref_i (s1_i_q),
    .vld_i     (s1_vld_q),
    .last_i    (win_last),
    .clr_i     (sync_clr),
    .sum_o     (mix_i_sum)
  );

  iq_mix_acc #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_mix_q (
    .clk       (clk),
    .reset     (reset),
    .sample_i  (s1_smp_q),
    .mix_ref_i (s1_q_q),
    .vld_i     (s1_vld_q),
    .last_i    (win_last),
    .clr_i     (sync_clr),
    .sum_o     (mix_q_sum)
  );

  // Output register FSM.
  always_comb begin
    state_d = state_q;
    i_sum_d = i_sum_q;
    q_sum_d = q_sum_q;
    drop    = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (win_end) begin
          i_sum_d = mix_i_sum;
          q_sum_d = mix_q_sum;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (win_end) begin
            i_sum_d = mix_i_sum;
            q_sum_d = mix_q_sum;
          end else begin
            state_d = ST_EMPTY;
          end
        end else if (win_end) begin
          drop = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // A drop in the same cycle as a clear wins: the flag stays set.
  always_comb begin
    ovr_d = ovr_q;
    if (overrun_clr) ovr_d = 1'b0;
    if (drop)        ovr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_smp_q <= '0;
      s1_i_q   <= 1'b0;
      s1_q_q   <= 1'b0;
      s1_vld_q <= 1'b0;
      cnt_q    <= '0;
      state_q  <= ST_EMPTY;
      i_sum_q  <= '0;
      q_sum_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      s1_smp_q <= s1_smp_d;
      s1_i_q   <= s1_i_d;
      s1_q_q   <= s1_q_d;
      s1_vld_q <= s1_vld_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      i_sum_q  <= i_sum_d;
      q_sum_q  <= q_sum_d;
      ovr_q    <= ovr_d;
    end
  end

  assign i_sum     = i_sum_q;
  assign q_sum     = q_sum_q;
  assign out_valid = (state_q == ST_FULL);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_rf_iq_demod.sv
module tb_rf_iq_demod;

  localparam int SW  = 8;
  localparam int WL  = 4;
  localparam int AW  = SW + WL + 1;
  localparam int WIN = 1 << WL;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [SW-1:0] rf_in = '0;
  logic                 rf_i = 1'b0, rf_q = 1'b0, en = 1'b0, sync_clr = 1'b0;
  logic                 out_ready = 1'b0, overrun_clr = 1'b0;
  logic signed [AW-1:0] i_sum, q_sum;
  logic                 out_valid, overrun;

  rf_iq_demod #(.SAMPLE_W(SW), .WIN_LOG2(WL)) dut (
    .clk         (clk),
    .reset       (rst),
    .rf_in       (rf_in),
    .rf_i        (rf_i),
    .rf_q        (rf_q),
    .en          (en),
    .sync_clr    (sync_clr),
    .i_sum       (i_sum),
    .q_sum       (q_sum),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  // Reference model: a sample presented with en becomes part of the window one
  // edge later (unless a restart intervenes); the window sum is plain integer
  // arithmetic, handed to the output register as soon as 2^WL samples are in.
  int   m_cnt, m_si, m_sq, m_fs, r_i, r_q;
  bit   m_fv, m_fi, m_fq, m_end, m_drop;
  bit   e_valid, e_ovr;
  int   e_i, e_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_si = 0; m_sq = 0; m_fv = 0; m_fs = 0; m_fi = 0; m_fq = 0;
      e_valid = 0; e_ovr = 0; e_i = 0; e_q = 0;
    end else begin
      m_end = 0;
      if (sync_clr) begin
        m_cnt = 0; m_si = 0; m_sq = 0; m_fv = 0;
      end else begin
        if (m_fv) begin
          m_si += m_fi ? m_fs : -m_fs;
          m_sq += m_fq ? m_fs : -m_fs;
          m_cnt++;
          if (m_cnt == WIN) begin
            m_end = 1; r_i = m_si; r_q = m_sq;
            m_cnt = 0; m_si = 0; m_sq = 0;
          end
        end
        m_fv = en; m_fs = int'(rf_in); m_fi = rf_i; m_fq = rf_q;
      end
      m_drop = 0;
      if (!e_valid) begin
        if (m_end) begin e_valid = 1; e_i = r_i; e_q = r_q; end
      end else if (out_ready) begin
        if (m_end) begin e_i = r_i; e_q = r_q; end
        else e_valid = 0;
      end else if (m_end) begin
        m_drop = 1;
      end
      if (overrun_clr) e_ovr = 0;
      if (m_drop)      e_ovr = 1;
    end
  end

  int n_chk = 0, n_err = 0, rises = 0;
  bit prev_v = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input int v, input bit ri, input bit rq);
    rf_in = v[SW-1:0]; rf_i = ri; rf_q = rq; en = 1'b1;
    tick();
  endtask

  task automatic idle();
    en = 1'b0;
    tick();
  endtask

  int base;

  initial begin
    fork
      forever begin
        @(negedge clk);
        chk("model_valid",   int'(out_valid), int'(e_valid));
        chk("model_overrun", int'(overrun),   int'(e_ovr));
        chk("model_i_sum",   int'(i_sum),     e_i);
        chk("model_q_sum",   int'(q_sum),     e_q);
        if (out_valid && !prev_v) rises++;
        prev_v = out_valid;
      end
    join_none

    tick(); tick();
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_i", int'(i_sum), 0);
    chk("reset_overrun", int'(overrun), 0);
    rst = 1'b0;
    tick();

    // +10, rf_i=1, rf_q toggling
    for (int k = 0; k < WIN; k++) smp(10, 1'b1, (k % 2) == 0);
    chk("lat_not_yet", int'(out_valid), 0);
    idle();
    chk("lat_valid", int'(out_valid), 1);
    chk("a_i", int'(i_sum), 160);
    chk("a_q", int'(q_sum), 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("drain_valid", int'(out_valid), 0);
    chk("drain_hold_i", int'(i_sum), 160);

    // full-scale negative sample, no wrap
    for (int k = 0; k < WIN; k++) smp(-128, 1'b0, 1'b1);
    idle();
    chk("b_i", int'(i_sum), 2048);
    chk("b_q", int'(q_sum), -2048);

    // second window while not ready: dropped
    for (int k = 0; k < WIN; k++) smp(5, 1'b1, 1'b1);
    idle();
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_hold_i", int'(i_sum), 2048);
    chk("ovr_hold_valid", int'(out_valid), 1);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    chk("ovr_clr", int'(overrun), 0);

    // ready on the same edge as the next window end
    for (int k = 0; k < WIN; k++) smp(3, 1'b1, 1'b0);
    en = 1'b0; out_ready = 1'b1; tick();
    chk("swap_valid", int'(out_valid), 1);
    chk("swap_i", int'(i_sum), 48);
    chk("swap_q", int'(q_sum), -48);
    tick(); out_ready = 1'b0;
    chk("swap_drain", int'(out_valid), 0);

    // restart coinciding with window end: no result
    for (int k = 0; k < WIN; k++) smp(9, 1'b1, 1'b1);
    en = 1'b0; sync_clr = 1'b1; tick(); sync_clr = 1'b0;
    tick();
    chk("clr_prio_valid", int'(out_valid), 0);

    // restart at sample 7, then 16 samples of +1
    for (int k = 0; k < 6; k++) smp(7, 1'b1, 1'b1);
    sync_clr = 1'b1; smp(7, 1'b1, 1'b1); sync_clr = 1'b0;
    for (int k = 0; k < WIN; k++) smp(1, 1'b1, 1'b1);
    idle();
    chk("clr_i", int'(i_sum), 16);
    chk("clr_valid", int'(out_valid), 1);

    // reset at sample 9 of a window
    for (int k = 0; k < 8; k++) smp(50, 1'b1, 1'b1);
    rf_in = 8'sd50; en = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_i", int'(i_sum), 0);
    chk("rst_q", int'(q_sum), 0);
    chk("rst_overrun", int'(overrun), 0);
    tick();
    rst = 1'b0; en = 1'b0;
    tick();
    for (int k = 0; k < WIN - 1; k++) smp(2, 1'b1, 1'b0);
    idle(); idle();
    chk("post_rst_short", int'(out_valid), 0);
    smp(2, 1'b1, 1'b0);
    idle();
    chk("post_rst_i", int'(i_sum), 32);
    chk("post_rst_q", int'(q_sum), -32);

    // en toggling every cycle for 32 cycles
    out_ready = 1'b1; tick(); tick(); out_ready = 1'b0;
    base = rises;
    for (int k = 0; k < 2 * WIN; k++) begin
      rf_in = k[SW-1:0]; en = (k % 2) == 0; rf_i = 1'b1; rf_q = (k % 4) == 0;
      tick();
    end
    idle(); idle();
    chk("tog_results", rises - base, 1);
    chk("tog_i", int'(i_sum), 240);
    chk("tog_q", int'(q_sum), -16);

    idle(); idle();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
